pipelined_modular_subtractor: RTL and testbench

Two-stage pipelined modular subtractor computing (a − b) mod M for operands already reduced to [0, M). It is the inverse of the fast modular adder: it recovers an operand from a modular sum, or negates a value when a = 0. It sits in the same modular-arithmetic datapath. A valid/ready handshake on both sides lets it sit between buffered stages with full backpressure at one result per cycle.

---
 rtl/modular_arith_pkg.sv | 27 ++
 rtl/carry_save_adder.sv | 20 ++
 rtl/pipelined_modular_subtractor_core.sv | 44 ++++
 rtl/ripple_carry_adder.sv | 21 ++
 rtl/pipelined_modular_subtractor.sv | 101 ++++++++++
 tb/tb_pipelined_modular_subtractor.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/modular_arith_pkg.sv
// Shared helpers for the modular-arithmetic datapath: parameter legality,
// modulus extension and two's-complement negation.
package modular_arith_pkg;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int          DEF_WIDTH = 8;
  localparam int          DEF_M     = 127;

  typedef logic [MAX_WIDTH:0] ext_t;

  // Operands must fit in WIDTH-1 bits of magnitude so a - b + M never overflows WIDTH.
  function automatic bit params_legal(int width, int m);
    longint lim;
    if (width < 2 || width > int'(MAX_WIDTH)) return 1'b0;
    lim = longint'(1) << (width - 1);
    return (m > 0) && (longint'(m) <= lim);
  endfunction

  function automatic ext_t m_ext(int m);
    return ext_t'(m);
  endfunction

  function automatic ext_t neg2c(ext_t x);
    return ~x + ext_t'(1);
  endfunction

endpackage

// File: rtl/carry_save_adder.sv
// Three-operand carry-save reduction; carry_o is already shifted one place left.
module carry_save_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  always_comb begin
    sum_o   = x_i ^ y_i ^ z_i;
    carry_o = '0;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      carry_o[i] = (x_i[i-1] & y_i[i-1]) | (x_i[i-1] & z_i[i-1]) | (y_i[i-1] & z_i[i-1]);
    end
  end

endmodule

// File: rtl/pipelined_modular_subtractor_core.sv
// modular_sub_core: combinational generation of a - b, a - b + M and the borrow.
module modular_sub_core
  import modular_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int M     = DEF_M
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] d0_o,
  output logic [WIDTH-1:0] d1_o,
  output logic             borrow_o
);

  localparam logic [WIDTH:0]   M_EXT = (WIDTH+1)'(m_ext(M));
  localparam logic [WIDTH-1:0] M_LOW = M_EXT[WIDTH-1:0];

  logic [WIDTH:0]   diff_full;
  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] csa_sum;
  logic [WIDTH-1:0] csa_carry;

  assign b_inv     = ~b_i;
  assign diff_full = {1'b0, a_i} + {1'b1, b_inv} + (WIDTH+1)'(1);
  assign d0_o      = diff_full[WIDTH-1:0];
  assign borrow_o  = diff_full[WIDTH];

  // Only the low WIDTH bits of a - b + M are ever selected, so that path stays WIDTH wide.
  carry_save_adder #(.WIDTH(WIDTH)) u_csa (
    .x_i     (a_i),
    .y_i     (b_inv),
    .z_i     (M_LOW),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
    .a_i   (csa_sum),
    .b_i   (csa_carry),
    .cin_i (1'b1),
    .sum_o (d1_o)
  );

endmodule

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder, result truncated to WIDTH bits.
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);

  always_comb begin
    logic c;
    sum_o = '0;
    c     = cin_i;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/pipelined_modular_subtractor.sv
// Two-stage (a - b) mod M with valid/ready on both sides.
// Optional operand range flag: define MODSUB_RANGE_CHECK_EN.
module pipelined_modular_subtractor
  import modular_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int M     = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_err
);

  if (!params_legal(WIDTH, M)) begin : g_bad_params
    $error("pipelined_modular_subtractor: illegal WIDTH/M combination");
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_d0_q;
  logic [WIDTH-1:0] s1_d1_q;
  logic             s1_borrow_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_diff_q;
  logic [WIDTH-1:0] out_diff_d;

  logic [WIDTH-1:0] core_d0;
  logic [WIDTH-1:0] core_d1;
  logic             core_borrow;
  logic             s1_en;
  logic             s2_en;

  modular_sub_core #(.WIDTH(WIDTH), .M(M)) u_core (
    .a_i      (a),
    .b_i      (b),
    .d0_o     (core_d0),
    .d1_o     (core_d1),
    .borrow_o (core_borrow)
  );

  assign s2_en      = !out_valid_q || out_ready;
  assign s1_en      = !s1_valid_q || s2_en;
  assign in_ready   = s1_en;
  assign out_diff_d = s1_borrow_q ? s1_d1_q : s1_d0_q;

`ifdef MODSUB_RANGE_CHECK_EN
  logic s1_err_q;
  logic out_err_q;
  logic in_err;
  assign in_err  = (a >= WIDTH'(M)) || (b >= WIDTH'(M));
  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_d0_q     <= '0;
      s1_d1_q     <= '0;
      s1_borrow_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
`ifdef MODSUB_RANGE_CHECK_EN
      s1_err_q    <= 1'b0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_d0_q     <= core_d0;
          s1_d1_q     <= core_d1;
          s1_borrow_q <= core_borrow;
`ifdef MODSUB_RANGE_CHECK_EN
          s1_err_q    <= in_err;
`endif
        end
      end
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_diff_q <= out_diff_d;
`ifdef MODSUB_RANGE_CHECK_EN
          out_err_q  <= s1_err_q;
`endif
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_diff  = out_diff_q;

endmodule

// File: tb/tb_pipelined_modular_subtractor.sv
// Directed bench for pipelined_modular_subtractor (WIDTH=8/M=127 plus a WIDTH=4/M=8 instance).
module tb_pipelined_modular_subtractor;

  typedef struct {
    logic [7:0] diff;
    bit         chkd;
    bit         err;
    int         acc;
    bit         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_err;
  logic [7:0] a, b, out_diff;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, out_err4;
  logic [3:0] a4, b4, out_diff4;

  int   checks = 0;
  int   errors = 0;
  int   cycle_n = 0;
  int   delivered = 0;
  exp_t sbq[$];
  int   q4[$];

  always #5 clk = ~clk;

  pipelined_modular_subtractor #(.WIDTH(8), .M(127)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_err(out_err)
  );

  pipelined_modular_subtractor #(.WIDTH(4), .M(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_diff(out_diff4), .out_err(out_err4)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit range_err(input int av, input int bv);
`ifdef MODSUB_RANGE_CHECK_EN
    return (av >= 127) || (bv >= 127);
`else
    return 1'b0;
`endif
  endfunction

  // One clock of main-DUT activity: drive at negedge, then score both handshakes.
  task automatic cyc(input bit v, input int av, input int bv, input int expd, input bit chkd,
                     input bit r, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    a         = av[7:0];
    b         = bv[7:0];
    out_ready = r;
    #1;
    cycle_n++;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        check("extra_result", int'(out_valid), 0);
      end else begin
        e = sbq[0];
        if (e.chkd) check("diff", int'(out_diff), int'(e.diff));
        check("err", int'(out_err), int'(e.err));
        if (r) begin
          void'(sbq.pop_front());
          delivered++;
          if (e.lat) check("latency", cycle_n - e.acc, 2);
        end
      end
    end
    acc = v && in_ready;
    if (acc) sbq.push_back('{expd[7:0], chkd, range_err(av, bv), cycle_n, lat});
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    int  dir [4][3];
    bit  acc;
    int  av, bv, calls, n_acc, base;

    dir = '{'{100, 27, 73}, '{5, 9, 123}, '{0, 1, 126}, '{42, 42, 0}};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;

    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_diff", int'(out_diff), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Isolated directed vectors with latency check
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, dir[i][0], dir[i][1], dir[i][2], 1'b1, 1'b1, 1'b1, acc);
      check("dir_accept", int'(acc), 1);
      idle(3);
    end
    check("dir_delivered", delivered, 4);

    // Backpressure: two fill the pipe, the third waits for out_ready
    cyc(1'b1, 10, 3, 7, 1'b1, 1'b0, 1'b0, acc);
    check("bp_acc1", int'(acc), 1);
    cyc(1'b1, 20, 30, 117, 1'b1, 1'b0, 1'b0, acc);
    check("bp_acc2", int'(acc), 1);
    cyc(1'b1, 50, 8, 42, 1'b1, 1'b0, 1'b0, acc);
    check("bp_full_in_ready", int'(in_ready), 0);
    cyc(1'b1, 50, 8, 42, 1'b1, 1'b0, 1'b0, acc);
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_diff", int'(out_diff), 7);
    base = delivered;
    cyc(1'b1, 50, 8, 42, 1'b1, 1'b1, 1'b0, acc);
    check("bp_release_acc", int'(acc), 1);
    check("bp_release_deliver", delivered - base, 1);
    idle(4);
    check("bp_drained", sbq.size(), 0);

    // Streaming random in-range pairs
    base = delivered; calls = 0; n_acc = 0;
    av = $urandom_range(0, 126); bv = $urandom_range(0, 126);
    while (n_acc < 200 && calls < 400) begin
      cyc(1'b1, av, bv, ((av - bv) % 127 + 127) % 127, 1'b1, 1'b1, 1'b0, acc);
      calls++;
      if (acc) begin
        n_acc++;
        av = $urandom_range(0, 126);
        bv = $urandom_range(0, 126);
      end
    end
    check("stream_cycles", calls, 200);
    idle(3);
    check("stream_results", delivered - base, 200);
    check("stream_drained", sbq.size(), 0);

`ifdef MODSUB_RANGE_CHECK_EN
    cyc(1'b1, 127, 3, 0, 1'b0, 1'b1, 1'b1, acc);
    cyc(1'b1, 126, 3, 123, 1'b1, 1'b1, 1'b1, acc);
    idle(3);
    check("range_drained", sbq.size(), 0);
`endif

    // Reset asserted between edges with two results in flight
    cyc(1'b1, 100, 27, 73, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 5, 9, 123, 1'b1, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid_full_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_diff", int'(out_diff), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, acc);
      check("no_stale", int'(out_valid), 0);
    end

    // Exhaustive WIDTH=4, M=8 instance
    n_acc = 0;
    for (int i = 0; i < 68; i++) begin
      @(negedge clk);
      in_valid4 = (i < 64);
      a4 = 4'(i / 8);
      b4 = 4'(i % 8);
      #1;
      if (out_valid4) begin
        if (q4.size() == 0) check("w4_extra", int'(out_valid4), 0);
        else begin
          check("w4_diff", int'(out_diff4), q4.pop_front());
          check("w4_err", int'(out_err4), 0);
          n_acc++;
        end
      end
      if (in_valid4 && in_ready4) q4.push_back(((i / 8 - i % 8) % 8 + 8) % 8);
    end
    check("w4_count", n_acc, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
